// File: rtl/note_synth_pkg.sv
// Shared constants, types and helpers for the note_synth tone generator.
package note_synth_pkg;

  localparam int unsigned PHASE_W = 24;
  localparam int unsigned LUT_AW  = 10;
  localparam int unsigned LUT_DW  = 12;

  localparam logic [7:0] NOTE_A    = 8'd65;
  localparam logic [7:0] NOTE_B    = 8'd66;
  localparam logic [7:0] NOTE_C    = 8'd67;
  localparam logic [7:0] NOTE_D    = 8'd68;
  localparam logic [7:0] NOTE_E    = 8'd69;
  localparam logic [7:0] NOTE_F    = 8'd70;
  localparam logic [7:0] NOTE_G    = 8'd71;
  localparam logic [7:0] NOTE_MUTE = 8'd0;

  // Tuning word = frequency * 256 at a 65536 samples/s rate
  localparam logic [PHASE_W-1:0] TW_A = 24'd112640;
  localparam logic [PHASE_W-1:0] TW_B = 24'd126208;
  localparam logic [PHASE_W-1:0] TW_C = 24'd66816;
  localparam logic [PHASE_W-1:0] TW_D = 24'd75008;
  localparam logic [PHASE_W-1:0] TW_E = 24'd84224;
  localparam logic [PHASE_W-1:0] TW_F = 24'd89344;
  localparam logic [PHASE_W-1:0] TW_G = 24'd100352;

  typedef enum logic {IDLE, PLAY} state_t;

  function automatic logic is_note(input logic [7:0] code);
    return (code >= NOTE_A) && (code <= NOTE_G);
  endfunction

  function automatic logic [PHASE_W-1:0] tuning_word(input logic [7:0] code);
    case (code)
      NOTE_A:  return TW_A;
      NOTE_B:  return TW_B;
      NOTE_C:  return TW_C;
      NOTE_D:  return TW_D;
      NOTE_E:  return TW_E;
      NOTE_F:  return TW_F;
      NOTE_G:  return TW_G;
      default: return '0;
    endcase
  endfunction

  // Quarter-wave entry sampled at bin centres: round(1023*sin(pi*(2i+1)/1024))
  function automatic logic [LUT_DW-3:0] quarter_sine(input int unsigned i);
    real ang;
    int  mag;
    ang = 3.14159265358979 * real'(2 * i + 1) / 1024.0;
    mag = $rtoi(1023.0 * $sin(ang) + 0.5);
    return mag[LUT_DW-3:0];
  endfunction

endpackage

// File: rtl/note_synth_sine_lut.sv
// Combinational full-wave sine lookup built from a quarter-wave table.
module sine_lut
  import note_synth_pkg::*;
(
  input  logic        [LUT_AW-1:0] addr_i,
  output logic signed [LUT_DW-1:0] sample_o
);

  logic        [LUT_DW-3:0] tab [256];
  logic        [1:0]        quad;
  logic        [7:0]        idx;
  logic signed [LUT_DW-1:0] mag;

  for (genvar g = 0; g < 256; g++) begin : g_tab
    assign tab[g] = quarter_sine(g);
  end

  // Odd quadrants mirror the index (255-i == ~i), upper half negates
  assign quad     = addr_i[LUT_AW-1:LUT_AW-2];
  assign idx      = quad[0] ? ~addr_i[7:0] : addr_i[7:0];
  assign mag      = {2'b00, tab[idx]};
  assign sample_o = quad[1] ? -mag : mag;

endmodule

// File: rtl/note_synth.sv
// Note-code driven sine tone generator with a valid/ready sample stream.
// Build option: NOTE_SYNTH_HOLD_EN removes the duration_p auto-mute.
module note_synth
  import note_synth_pkg::*;
#(
  parameter int unsigned int_out_p  = 2,
  parameter int unsigned frac_out_p = 10,
  parameter int unsigned duration_p = 65536
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [7:0]                             note_i,
  input  logic                                   update_i,
  input  logic                                   ready_i,
  output logic                                   valid_o,
  output logic signed [int_out_p+frac_out_p-1:0] audio_o,
  output logic                                   playing_o,
  output logic [7:0]                             note_o
);

  localparam int unsigned AW = int_out_p + frac_out_p;

  state_t                   state_q, state_d;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic [7:0]               note_q, note_d;
  logic [7:0]               pend_code_q;
  logic                     pend_q;
  logic                     valid_q;
  logic signed [AW-1:0]     audio_q, audio_d;

  logic                     hs;
  logic                     apply;
  logic [7:0]               apply_code;
  logic                     start_note;
  logic                     timeout;
  logic [LUT_AW-1:0]        lut_addr;
  logic signed [LUT_DW-1:0] lut_sample;

  assign hs         = valid_q & ready_i;
  // A strobe coinciding with a handshake overrides the stored pending note
  assign apply      = update_i | pend_q;
  assign apply_code = update_i ? note_i : pend_code_q;
  assign start_note = apply & is_note(apply_code);
  assign lut_addr   = start_note ? '0 : phase_q[PHASE_W-1:PHASE_W-LUT_AW];

  sine_lut u_lut (
    .addr_i   (lut_addr),
    .sample_o (lut_sample)
  );

`ifdef NOTE_SYNTH_HOLD_EN
  assign timeout = 1'b0;
`else
  localparam int unsigned CW = $clog2(duration_p + 1);

  logic [CW-1:0] cnt_q;

  assign timeout = (cnt_q == CW'(duration_p));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (hs) begin
      if (start_note)
        cnt_q <= CW'(1);
      else if (!apply && state_q == PLAY && !timeout)
        cnt_q <= cnt_q + CW'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    note_d  = note_q;
    audio_d = audio_q;
    if (hs) begin
      if (start_note) begin
        state_d = PLAY;
        note_d  = apply_code;
        audio_d = AW'(lut_sample);
        phase_d = tuning_word(apply_code);
      end else if (apply || (state_q == PLAY && timeout)) begin
        state_d = IDLE;
        note_d  = '0;
        audio_d = '0;
      end else if (state_q == PLAY) begin
        audio_d = AW'(lut_sample);
        phase_d = phase_q + tuning_word(note_q);
      end else begin
        audio_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      note_q      <= '0;
      audio_q     <= '0;
      valid_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      note_q  <= note_d;
      audio_q <= audio_d;
      valid_q <= 1'b1;
      if (hs) begin
        pend_q <= 1'b0;
      end else if (update_i) begin
        pend_q      <= 1'b1;
        pend_code_q <= note_i;
      end
    end
  end

  assign valid_o   = valid_q;
  assign audio_o   = audio_q;
  assign playing_o = (state_q == PLAY);
  assign note_o    = note_q;

endmodule

// File: tb/tb_note_synth.sv
// Directed self-checking bench for note_synth (default and short-duration instances).
module tb_note_synth;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [7:0]        note_i, t_note;
  logic              update_i, t_update;
  logic              ready_i, t_ready;
  logic              valid_o, t_valid;
  logic signed [11:0] audio_o, t_audio;
  logic              playing_o, t_playing;
  logic [7:0]        note_o, t_note_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  note_synth #(.int_out_p(2), .frac_out_p(10), .duration_p(65536)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .note_i    (note_i),
    .update_i  (update_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .audio_o   (audio_o),
    .playing_o (playing_o),
    .note_o    (note_o)
  );

  note_synth #(.int_out_p(2), .frac_out_p(10), .duration_p(4)) dut_t (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .note_i    (t_note),
    .update_i  (t_update),
    .ready_i   (t_ready),
    .valid_o   (t_valid),
    .audio_o   (t_audio),
    .playing_o (t_playing),
    .note_o    (t_note_o)
  );

  function automatic int lut_model(input logic [23:0] ph);
    logic [1:0] q;
    int         i, m;
    q = ph[23:22];
    i = int'(ph[21:14]);
    if (q[0]) i = 255 - i;
    m = $rtoi(1023.0 * $sin(3.14159265358979 * real'(2 * i + 1) / 1024.0) + 0.5);
    return q[1] ? -m : m;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic signed [11:0] held;
    logic [23:0]        ph;

    reset_i  = 1'b1;
    note_i   = '0;  update_i = 1'b0; ready_i = 1'b1;
    t_note   = '0;  t_update = 1'b0; t_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_audio", audio_o, 0);
    chk("rst_playing", playing_o, 0);
    chk("rst_note", note_o, 0);

    reset_i = 1'b0;
    tick();
    chk("rel_valid", valid_o, 1);
    chk("rel_audio", audio_o, 0);

    // Note A with ready held high
    update_i = 1'b1; note_i = 8'd65;
    tick();
    update_i = 1'b0; note_i = 8'd0;
    chk("a_s0", audio_o, 3);
    chk("a_playing", playing_o, 1);
    chk("a_note", note_o, 65);
    tick();
    chk("a_s1", audio_o, 41);
    tick();
    chk("a_s2", audio_o, 85);
    for (int n = 3; n < 80; n++) begin
      tick();
      ph = 24'(n * 112640);
      chk("a_seq", audio_o, lut_model(ph));
      if (n == 75) chk("a_s75_neg", audio_o < 0, 1);
    end

    // Backpressure: output frozen, sequence resumes without gaps
    held    = audio_o;
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_hold", audio_o, held);
    end
    chk("stall_valid", valid_o, 1);
    ready_i = 1'b1;
    tick();
    chk("resume_s80", audio_o, lut_model(24'(80 * 112640)));
    tick();
    chk("resume_s81", audio_o, lut_model(24'(81 * 112640)));

    // Mute code
    update_i = 1'b1; note_i = 8'd88;
    tick();
    update_i = 1'b0;
    chk("mute_audio", audio_o, 0);
    chk("mute_playing", playing_o, 0);
    chk("mute_note", note_o, 0);
    tick();
    chk("mute_idle", audio_o, 0);

    // Two updates while stalled: last one wins
    ready_i = 1'b0;
    update_i = 1'b1; note_i = 8'd67;
    tick();
    note_i = 8'd71;
    tick();
    update_i = 1'b0; note_i = 8'd0;
    tick();
    chk("pend_stall_audio", audio_o, 0);
    chk("pend_stall_playing", playing_o, 0);
    ready_i = 1'b1;
    tick();
    chk("g_s0", audio_o, 3);
    chk("g_note", note_o, 71);
    chk("g_playing", playing_o, 1);
    tick();
    chk("g_s1", audio_o, 41);
    tick();
    chk("g_s2", audio_o, lut_model(24'd200704));

    // Asynchronous reset mid-note discards a pending note
    ready_i = 1'b0;
    update_i = 1'b1; note_i = 8'd65;
    tick();
    update_i = 1'b0; note_i = 8'd0;
    #3 reset_i = 1'b1;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_audio", audio_o, 0);
    chk("arst_playing", playing_o, 0);
    chk("arst_note", note_o, 0);
    #2 reset_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk("arst_rel_valid", valid_o, 1);
    tick();
    chk("arst_no_pend_audio", audio_o, 0);
    chk("arst_no_pend_playing", playing_o, 0);
    chk("arst_no_pend_note", note_o, 0);

    // Short-duration instance: C for four samples
    t_update = 1'b1; t_note = 8'd67;
    tick();
    t_update = 1'b0; t_note = 8'd0;
    chk("c_s0", t_audio, 3);
    chk("c_playing", t_playing, 1);
    tick();
    chk("c_s1", t_audio, lut_model(24'd66816));
    tick();
    chk("c_s2", t_audio, lut_model(24'd133632));
    tick();
    chk("c_s3", t_audio, lut_model(24'd200448));
    chk("c_s3_playing", t_playing, 1);
    tick();
`ifdef NOTE_SYNTH_HOLD_EN
    chk("c_hold_s4", t_audio, lut_model(24'd267264));
    chk("c_hold_playing", t_playing, 1);
    chk("c_hold_note", t_note_o, 67);
    tick();
    chk("c_hold_s5", t_audio, lut_model(24'd334080));
`else
    chk("c_timeout_audio", t_audio, 0);
    chk("c_timeout_playing", t_playing, 0);
    chk("c_timeout_note", t_note_o, 0);
    tick();
    chk("c_after_timeout", t_audio, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
